// File: rtl/os_acc_drain.sv
// Drain stage for one row of output-stationary accumulators: snapshots the row,
// requantizes each element (rounding shift, optional ReLU, saturation) and streams it out.
module os_acc_drain #(
  parameter int N           = 4,
  parameter int ACC_WIDTH   = 64,
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        capture_i,
  input  logic [N*ACC_WIDTH-1:0]      acc_row_i,
  input  logic [SHIFT_WIDTH-1:0]      shift_i,
  input  logic                        relu_en_i,
  output logic                        busy_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic [$clog2(N)-1:0]        out_idx_o,
  output logic                        out_last_o,
  output logic                        done_o,
  output logic                        sat_o
);

  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic signed [ACC_WIDTH:0] ONE   = 1;
  localparam logic signed [ACC_WIDTH:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_DRAIN} state_e;

  state_e                  state_q;
  logic [ACC_WIDTH-1:0]    snap_q [N];
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic                    relu_q;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [IDXW-1:0]         out_idx_q;
  logic                    out_last_q;
  logic                    done_q;
  logic                    sat_q;

  logic [IDXW-1:0]         idx_d;
  logic [ACC_WIDTH-1:0]    sel_acc;
  logic [SHIFT_WIDTH-1:0]  sel_shift;
  logic                    sel_relu;
  logic [DATA_WIDTH-1:0]   elem_d;
  logic                    elem_sat_d;
  int                      s_eff;
  logic signed [ACC_WIDTH:0] ext_v, rnd_v, res_v;

  // In IDLE the element being loaded is element 0 straight from the inputs, so it
  // can appear the cycle after capture; in DRAIN it is the next snapshot element.
  always_comb begin
    idx_d     = out_idx_q + IDX_ONE;
    sel_acc   = '0;
    sel_shift = shift_q;
    sel_relu  = relu_q;
    if (state_q == S_IDLE) begin
      sel_acc   = acc_row_i[0 +: ACC_WIDTH];
      sel_shift = shift_i;
      sel_relu  = relu_en_i;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (IDXW'(k) == idx_d) sel_acc = snap_q[k];
      end
    end
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    s_eff = (int'(sel_shift) >= ACC_WIDTH) ? ACC_WIDTH - 1 : int'(sel_shift);
    ext_v = {sel_acc[ACC_WIDTH-1], sel_acc};
    rnd_v = ext_v;
    if (s_eff > 0) rnd_v = ext_v + (ONE <<< (s_eff - 1));
    res_v = rnd_v >>> s_eff;
    if (sel_relu && res_v[ACC_WIDTH]) res_v = '0;
    elem_sat_d = 1'b0;
    if (res_v > MAX_V) begin
      res_v      = MAX_V;
      elem_sat_d = 1'b1;
    end else if (res_v < MIN_V) begin
      res_v      = MIN_V;
      elem_sat_d = 1'b1;
    end
    elem_d = res_v[DATA_WIDTH-1:0];
  end

  // Handshake: an element transfers on a rising edge where out_valid_o and
  // out_ready_i are both 1; out_valid_o is a register and never looks at out_ready_i.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < N; k++) snap_q[k] <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (capture_i) begin
            for (int k = 0; k < N; k++) snap_q[k] <= acc_row_i[k*ACC_WIDTH +: ACC_WIDTH];
            shift_q     <= shift_i;
            relu_q      <= relu_en_i;
            out_valid_q <= 1'b1;
            out_data_q  <= elem_d;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= elem_sat_d;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready_i) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              out_data_q <= elem_d;
              out_idx_q  <= idx_d;
              out_last_q <= (idx_d == LAST_IDX);
              sat_q      <= sat_q | elem_sat_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == S_DRAIN);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_os_acc_drain.sv
// Bench for os_acc_drain: directed rows plus random rows, checked against an
// arithmetic requantization model and an expected-element queue.
module tb_os_acc_drain;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 16;
  localparam int SW = 6;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            capture_i = 1'b0;
  logic [N*AW-1:0] acc_row_i = '0;
  logic [SW-1:0]   shift_i = '0;
  logic            relu_en_i = 1'b0;
  logic            busy_o;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [DW-1:0]   out_data_o;
  logic [IW-1:0]   out_idx_o;
  logic            out_last_o;
  logic            done_o;
  logic            sat_o;

  os_acc_drain #(.N(N), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rstn(rstn), .capture_i(capture_i), .acc_row_i(acc_row_i),
    .shift_i(shift_i), .relu_en_i(relu_en_i), .busy_o(busy_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_idx_o(out_idx_o), .out_last_o(out_last_o), .done_o(done_o), .sat_o(sat_o)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  bit            sat_exp_q[$];
  bit            sat_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rounding shift expressed as floor(x/2^s) plus the half bit.
  function automatic void model(input longint acc, input int s, input bit relu,
                                output longint r, output bit sat);
    longint q;
    int se;
    se = (s >= AW) ? AW - 1 : s;
    if (se == 0) q = acc;
    else begin
      q = acc >>> se;
      if (acc[se-1]) q = q + 1;
    end
    if (relu && q < 0) q = 0;
    sat = 1'b0;
    if (q > 32767) begin q = 32767; sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
    r = q;
  endfunction

  function automatic logic [N*AW-1:0] pack(input longint a0, input longint a1,
                                           input longint a2, input longint a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [N*AW-1:0] rand_row();
    logic [N*AW-1:0] row;
    longint v;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 2))
        0: v = {$urandom, $urandom};
        1: v = longint'($urandom_range(0, 2000000)) - 1000000;
        default: v = longint'($urandom_range(0, 80000)) - 40000;
      endcase
      row[k*AW +: AW] = v;
    end
    return row;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid_o, 0);
    check({tag, "_data"}, out_data_o, 0);
    check({tag, "_idx"}, out_idx_o, 0);
    check({tag, "_last"}, out_last_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_sat"}, sat_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic apply_reset();
    acc_row_i = rand_row();
    shift_i   = SW'($urandom_range(0, 63));
    relu_en_i = 1'($urandom_range(0, 1));
    capture_i = 1'($urandom_range(0, 1));
    rstn = 1'b0;
    #2;
    check_zero("rst_async");
    tick();
    check_zero("rst_hold");
    #2;
    rstn = 1'b1;
    capture_i = 1'b0;
    exp_q.delete();
    sat_exp_q.delete();
    sat_hold = 1'b0;
    tick();
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_valid", out_valid_o, 0);
      check("idle_busy", busy_o, 0);
      check("idle_done", done_o, 0);
      check("idle_sat", sat_o, sat_hold);
    end
  endtask

  // driver + scoreboard for one row; ends in the done cycle
  task automatic run_row(input logic [N*AW-1:0] row, input int s, input bit relu,
                         input int stall_idx, input bit rnd_stall, input int abort_at);
    longint r;
    bit st;
    bit sat_acc;
    int stalls;
    logic [DW-1:0] exp_d;
    for (int k = 0; k < N; k++) begin
      model(longint'(row[k*AW +: AW]), s, relu, r, st);
      exp_q.push_back(r[DW-1:0]);
      sat_exp_q.push_back(st);
    end
    acc_row_i = row;
    shift_i   = SW'(s);
    relu_en_i = relu;
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    acc_row_i = rand_row();
    shift_i   = SW'($urandom_range(0, 63));
    relu_en_i = 1'($urandom_range(0, 1));
    sat_acc = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_d = exp_q.pop_front();
      sat_acc |= sat_exp_q.pop_front();
      if (k == abort_at) begin
        rstn = 1'b0;
        #2;
        check_zero("abort");
        #2;
        rstn = 1'b1;
        exp_q.delete();
        sat_exp_q.delete();
        sat_hold = 1'b0;
        return;
      end
      stalls = (k == stall_idx) ? 3 : (rnd_stall ? $urandom_range(0, 2) : 0);
      for (int j = 0; j <= stalls; j++) begin
        check("valid", out_valid_o, 1);
        check("data", out_data_o, exp_d);
        check("idx", out_idx_o, k);
        check("last", out_last_o, (k == N - 1));
        check("busy", busy_o, 1);
        check("done_mid", done_o, 0);
        check("sat", sat_o, sat_acc);
        if (j < stalls) begin
          out_ready_i = 1'b0;
          capture_i = (j == 1);
          acc_row_i = rand_row();
          shift_i   = SW'($urandom_range(0, 63));
          tick();
          capture_i = 1'b0;
        end
      end
      out_ready_i = 1'b1;
      tick();
    end
    check("end_valid", out_valid_o, 0);
    check("end_done", done_o, 1);
    check("end_busy", busy_o, 0);
    check("end_sat", sat_o, sat_acc);
    sat_hold = sat_acc;
  endtask

  initial begin
    // reset with random inputs, then no output until a capture
    apply_reset();
    idle_check(3);
    out_ready_i = 1'b1;

    run_row(pack(100, -100, 7, 0), 0, 0, -1, 0, -1);
    idle_check(1);
    run_row(pack(5, -5, 6, -6), 1, 0, -1, 0, -1);
    run_row(pack(1023, -1024, 0, 1), 10, 0, -1, 0, -1);
    idle_check(2);

    run_row(pack(40000, -40000, 32767, -32768), 0, 0, -1, 0, -1);
    run_row(pack(40000, -40000, 32767, -32768), 0, 1, -1, 0, -1);
    run_row(pack(-40000, 0, 0, 0), 0, 1, -1, 0, -1);
    idle_check(1);

    // backpressure at idx 1 with an ignored capture during the stall
    run_row(rand_row(), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1, 0, -1);
    run_row(pack(-1, 65535, -65536, 12345), 2, 0, -1, 0, -1);
    idle_check(1);

    // reset after two elements have transferred, then a fresh row
    run_row(rand_row(), 4, 0, -1, 0, 2);
    idle_check(2);
    run_row(pack(11, 22, -33, 44), 0, 0, -1, 0, -1);
    run_row(pack(64'sh7fff_ffff_ffff_ffff, 64'sh8000_0000_0000_0000, 3, -3), 63, 0, -1, 0, -1);

    for (int i = 0; i < 40; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 12);
      run_row(rand_row(), s, 1'($urandom_range(0, 1)), -1, 1, -1);
      idle_check($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
